// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues aligned 8-byte reads and holds one instruction for IF/ID.
// Optional macro FETCH_LINE_REUSE_EN serves the upper word of a fetched line without a second memory read.
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [63:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        id_ready,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [63:0] out_inst
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

  state_t      state_q;
  logic [63:0] pc_q;
  logic [63:0] line_hold_q;
  logic [31:0] inst_hold_q;
  logic        line_ok_q;

  logic [63:0] redir_pc_d;
  logic [63:0] pc_inc_d;
  logic        consume;
  logic        reuse_hit;

  assign redir_pc_d = redirect_pc & ~64'h3;
  assign pc_inc_d   = pc_q + 64'd4;

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = {pc_q[63:3], 3'b000};
  // Redirect is the only input allowed to reach an output combinationally.
  assign out_valid      = (state_q == HOLD) && !redirect_valid;
  assign out_pc         = pc_q;
  assign out_inst       = {32'b0, inst_hold_q};

  assign consume   = out_valid && id_ready;
  assign reuse_hit = consume && !pc_q[2] && line_ok_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      inst_hold_q <= 32'b0;
      line_hold_q <= 64'b0;
    end else begin
      unique case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          if (redirect_valid) begin
            pc_q    <= redir_pc_d;
            state_q <= imem_req_ready ? DRAIN : REQ;
          end else if (imem_req_ready) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            pc_q    <= redir_pc_d;
            state_q <= imem_resp_valid ? REQ : DRAIN;
          end else if (imem_resp_valid) begin
            inst_hold_q <= pc_q[2] ? imem_resp_data[63:32] : imem_resp_data[31:0];
            line_hold_q <= imem_resp_data;
            state_q     <= HOLD;
          end
        end
        // A redirect here only retargets; the in-flight response must still be swallowed.
        DRAIN: begin
          if (redirect_valid) pc_q <= redir_pc_d;
          if (imem_resp_valid) state_q <= REQ;
        end
        HOLD: begin
          if (redirect_valid) begin
            pc_q    <= redir_pc_d;
            state_q <= REQ;
          end else if (id_ready) begin
            pc_q <= pc_inc_d;
            if (reuse_hit) inst_hold_q <= line_hold_q[63:32];
            else           state_q     <= REQ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FETCH_LINE_REUSE_EN
  // Upper word of the held line is reusable only right after a fresh response.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_ok_q <= 1'b0;
    end else if (redirect_valid && state_q != IDLE) begin
      line_ok_q <= 1'b0;
    end else if (state_q == WAIT && imem_resp_valid) begin
      line_ok_q <= 1'b1;
    end else if (reuse_hit) begin
      line_ok_q <= 1'b0;
    end
  end
`else
  assign line_ok_q = 1'b0;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the 64-bit pipeline. Owns the architectural fetch PC and issues aligned 8-byte reads to the instruction memory port. It holds each fetched 32-bit instruction until the IF/ID interstage accepts it. It also handles redirects from branch resolution, including a redirect that arrives while a memory read is still outstanding.

## Interface
- RESET_PC, 64'h0: PC loaded on reset; bits [1:0] must be 0.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high; clock clk
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  64  read address = {pc[63:3], 3'b000}
- imem_resp_valid  in  1  read data valid; exactly one per accepted request, ≥1 cycle after acceptance
- imem_resp_data  in  64  read data
- redirect_valid  in  1  replace PC this cycle (taken branch/jump from EX)
- redirect_pc  in  64  new PC; bits [1:0] ignored (treated as 0)
- id_ready  in  1  IF/ID register will clock in this cycle (its wr_en)
- out_valid  out  1  instruction present; IF/ID gen_bubble = !out_valid
- out_pc  out  64  PC of presented instruction
- out_inst  out  64  instruction, zero-extended from 32 bits

## Operation
- Registers:
  - pc (64)
  - inst_hold (32)
  - line_hold (64)
  - line_ok (1)
  - state: IDLE, REQ, WAIT, HOLD, DRAIN
- Output decode:
  - imem_req_valid = (state==REQ)
  - out_valid = (state==HOLD) && !redirect_valid
  - out_pc = pc
  - out_inst = {32'b0, inst_hold}
- An instruction is consumed when out_valid && id_ready.
- IDLE: go to REQ next cycle.
- REQ:
  - If imem_req_ready: go to WAIT.
  - If redirect_valid in the same cycle: pc←redirect_pc. Next state is DRAIN if imem_req_ready, otherwise REQ.
- WAIT, on imem_resp_valid:
  - inst_hold←pc[2] ? data[63:32] : data[31:0]
  - line_hold←data
  - go to HOLD
- WAIT with redirect_valid:
  - pc←redirect_pc.
  - If imem_resp_valid in the same cycle: data discarded, go to REQ.
  - Otherwise go to DRAIN.
- DRAIN: discard the next imem_resp_valid, then go to REQ. A redirect during DRAIN updates pc and stays in DRAIN.
- HOLD:
  - redirect_valid: pc←redirect_pc, go to REQ. No consume happens.
  - Else on consume: pc←pc+4 (wraps mod 2^64), go to REQ. The reuse exception is described under Configuration.
  - Else stay in HOLD; outputs stay stable.
- Redirect has priority over every other event in every state except IDLE, where it is ignored.
- imem_resp_valid seen in IDLE, REQ or HOLD is ignored. This covers stale responses after a reset.

## Timing
- Reset values:
  - state=IDLE
  - pc=RESET_PC
  - inst_hold=0, line_hold=0, line_ok=0
  - imem_req_valid=0, out_valid=0
  - out_pc=RESET_PC, out_inst=0
- Reset applied mid-operation aborts any outstanding request. The response to that request is ignored.
- First request is on cycle 1 after reset deasserts.
- Zero-wait memory latency:
  - Request accepted in cycle N.
  - Response in N+1.
  - out_valid in N+2.
  - Next request in N+3 after consume in N+2.
  - Throughput is 1 instruction per 3 cycles.
- Redirect takes effect on the next cycle. The cycle after a redirect, imem_req_addr reflects redirect_pc (in REQ), or a drain is in progress.
- All outputs are registered-state decodes. The only combinational input-to-output path is redirect_valid → out_valid.

## Configuration
- FETCH_LINE_REUSE_EN defined:
  - line_ok is set on every HOLD entry from a memory response.
  - On consume with pc[2]==0 and line_ok: pc←pc+4, inst_hold←line_hold[63:32], line_ok←0, stay in HOLD. No memory request is issued.
  - Redirect clears line_ok.
- FETCH_LINE_REUSE_EN undefined: line_ok is constant 0, and every consume goes to REQ.

## Test plan
- Reset, memory ready with 1-cycle response, id_ready=1, RESET_PC=0x1000:
  - Addresses issued are 0x1000, 0x1000, 0x1008…
  - out_pc sequence is 0x1000, 0x1004, 0x1008.
  - inst is the low word, then the high word, then the low word.
- id_ready=0 for 5 cycles while in HOLD: out_valid/out_pc/out_inst are held, and there is no imem_req_valid.
- Redirect to 0x2002 while in WAIT, with the response 2 cycles later:
  - The response is dropped.
  - The next request address is 0x2000.
  - The first out_pc is 0x2000.
  - The stale instruction is never valid.
- Redirect and imem_resp_valid in the same WAIT cycle: the data is discarded, and the next cycle is REQ at redirect_pc.
- With FETCH_LINE_REUSE_EN, fetching at pc=0x1000 consumes 0x1000 and then 0x1004 with a single memory request. Without the macro, there are two requests.
- Reset asserted in WAIT, with the response arriving 1 cycle after reset deasserts: the response is ignored, and the first out_pc is RESET_PC.
